// File: rtl/md_sched.sv
// Multiply/divide sequencer: accepts one long op, drives the mul/div unit handshake,
// commits results to HI/LO, executes MTHI/MTLO and stalls the pipeline while busy.
module md_sched #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         stall,
  output logic [W-1:0] unit_a,
  output logic [W-1:0] unit_b,
  output logic         mul_start,
  output logic         mul_signed,
  input  logic         mul_done,
  input  logic [W-1:0] mul_hi,
  input  logic [W-1:0] mul_lo,
  output logic         div_start,
  output logic         div_signed,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         dbz,
  output logic         tmo
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           is_div_q, is_div_d;
  logic           sgn_q, sgn_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dbz_q, dbz_d;
  logic           tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      dbz_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      dbz_q    <= dbz_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    tmo_d     = tmo_q;
    stall     = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!req_op[2]) begin
            // op[1] selects divide, op[0] selects unsigned
            a_d      = req_a;
            b_d      = req_b;
            is_div_d = req_op[1];
            sgn_d    = ~req_op[0];
            dbz_d    = 1'b0;
            tmo_d    = 1'b0;
            stall    = 1'b1;
            state_d  = S_ISSUE;
          end else if (req_op == 3'b100) begin
            hi_d = req_a;
          end else if (req_op == 3'b101) begin
            lo_d = req_a;
          end
        end
      end
      S_ISSUE: begin
        stall = 1'b1;
        cnt_d = '0;
        if (!is_div_q) begin
          mul_start = 1'b1;
          state_d   = S_WAIT;
        end else if (b_q != '0) begin
          div_start = 1'b1;
          state_d   = S_WAIT;
        end else begin
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        // a done arriving in the last allowed cycle still wins over the timeout
        if (!is_div_q && mul_done) begin
          hi_d    = mul_hi;
          lo_d    = mul_lo;
          state_d = S_DONE;
        end else if (is_div_q && div_done) begin
          hi_d    = div_r;
          lo_d    = div_q;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign mul_signed = (state_q != S_IDLE) && !is_div_q && sgn_q;
  assign div_signed = (state_q != S_IDLE) &&  is_div_q && sgn_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign dbz        = (state_q == S_DONE) && dbz_q;
  assign tmo        = (state_q == S_DONE) && tmo_q;

endmodule

// File: tb/tb_md_sched.sv
// Randomized bench for md_sched; the bench plays the mul/div units and tracks HI/LO
// with an arithmetic reference model of each instruction's effect and timing.
module tb_md_sched;
  localparam int W  = 32;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a, req_b;
  logic          stall, mul_start, mul_signed, div_start, div_signed;
  logic [W-1:0]  unit_a, unit_b;
  logic          mul_done, div_done;
  logic [W-1:0]  mul_hi, mul_lo, div_q, div_r;
  logic [W-1:0]  hi, lo;
  logic          dbz, tmo;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] hi_m, lo_m;

  md_sched #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .stall(stall),
    .unit_a(unit_a), .unit_b(unit_b),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_done(mul_done),
    .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_start(div_start), .div_signed(div_signed), .div_done(div_done),
    .div_q(div_q), .div_r(div_r),
    .hi(hi), .lo(lo), .dbz(dbz), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Unit inputs idle, with garbage on the result buses so only real done pulses matter.
  task automatic quiet_units();
    mul_done = 1'b0;
    div_done = 1'b0;
    mul_hi   = $urandom;
    mul_lo   = $urandom;
    div_q    = $urandom;
    div_r    = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_cycle(input string tag);
    req_valid = 1'b0;
    quiet_units();
    @(negedge clk);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_msgn"}, mul_signed, 0);
    chk({tag, "_dsgn"}, div_signed, 0);
    chk({tag, "_hi"}, hi, hi_m);
    chk({tag, "_lo"}, lo, lo_m);
    next_cycle();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_a     = '0;
    req_b     = '0;
    quiet_units();
    next_cycle();
    next_cycle();
    rst  = 1'b0;
    hi_m = '0;
    lo_m = '0;
  endtask

  // MTHI / MTLO / no-op: single-cycle, never stalls, visible next cycle.
  task automatic run_short(input logic [2:0] op, input logic [W-1:0] a);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = $urandom;
    quiet_units();
    @(negedge clk);
    chk("mt_stall", stall, 0);
    chk("mt_hi_before", hi, hi_m);
    chk("mt_lo_before", lo, lo_m);
    next_cycle();
    if (op == 3'b100) hi_m = a;
    if (op == 3'b101) lo_m = a;
    check_idle_cycle("mt_after");
  endtask

  // Long op. k = cycle (relative to accept) at which the unit answers, 0 = never.
  // junk: same-unit done pulses in ISSUE and DONE; oth_c: cycle of other-unit done (-1 none).
  task automatic run_long(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int k, input bit junk, input int oth_c);
    bit is_div, sg, dbz_e, tmo_e, commit;
    int e;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    logic [W-1:0] nh, nl;
    is_div = op[1];
    sg     = ~op[0];
    dbz_e  = is_div && (b == 0);
    tmo_e  = !dbz_e && (k == 0);
    commit = !dbz_e && !tmo_e;
    e      = dbz_e ? 1 : (tmo_e ? TO + 1 : k);
    sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    nh = '0;
    nl = '0;
    if (!is_div) begin
      p  = sa * sb;
      nh = p[63:32];
      nl = p[31:0];
    end else if (b != 0) begin
      sq = sa / sb;
      sr = sa % sb;
      nl = sq[31:0];
      nh = sr[31:0];
    end
    for (int c = 0; c <= e + 1; c++) begin
      req_valid = 1'b1;
      req_op    = op;
      req_a     = (c == 0) ? a : W'($urandom);
      req_b     = (c == 0) ? b : W'($urandom);
      quiet_units();
      if (commit && c == k) begin
        if (is_div) begin div_done = 1'b1; div_q = nl; div_r = nh; end
        else        begin mul_done = 1'b1; mul_hi = nh; mul_lo = nl; end
      end
      if (junk && (c == 1 || c == e + 1)) begin
        if (is_div) div_done = 1'b1;
        else        mul_done = 1'b1;
      end
      if (c == oth_c && c >= 2 && c < e) begin
        if (is_div) mul_done = 1'b1;
        else        div_done = 1'b1;
      end
      @(negedge clk);
      chk("stall", stall, (c <= e) ? 1 : 0);
      chk("mul_start", mul_start, (c == 1 && !is_div) ? 1 : 0);
      chk("div_start", div_start, (c == 1 && is_div && !dbz_e) ? 1 : 0);
      chk("dbz", dbz, (c == e + 1 && dbz_e) ? 1 : 0);
      chk("tmo", tmo, (c == e + 1 && tmo_e) ? 1 : 0);
      chk("hi", hi, hi_m);
      chk("lo", lo, lo_m);
      if (c == 1) begin
        chk("unit_a", unit_a, a);
        chk("unit_b", unit_b, b);
        chk("mul_signed", mul_signed, (!is_div && sg) ? 1 : 0);
        chk("div_signed", div_signed, (is_div && sg) ? 1 : 0);
      end
      if (c >= 2 && c <= e) begin
        chk("unit_a_hold", unit_a, a);
        chk("unit_b_hold", unit_b, b);
      end
      next_cycle();
      if (commit && c == e) begin
        hi_m = nh;
        lo_m = nl;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_b", unit_b, 0);
    chk("rst_pulses", {mul_start, div_start, mul_signed, div_signed, dbz, tmo}, 0);
    next_cycle();

    run_short(3'b100, 32'h12345678);
    run_long(3'b000, 32'hFFFFFFFD, 32'd5, 4, 1'b0, -1);
    chk("mult_hi_val", hi, 32'hFFFFFFFF);
    chk("mult_lo_val", lo, 32'hFFFFFFF1);
    run_long(3'b011, 32'd100, 32'd7, 10, 1'b0, 5);
    chk("divu_hi_val", hi, 32'd2);
    chk("divu_lo_val", lo, 32'd14);
    run_long(3'b010, 32'd5, 32'd0, 0, 1'b1, -1);
    run_long(3'b011, 32'd9, 32'd3, 0, 1'b0, -1);
    run_short(3'b101, 32'hCAFEF00D);
    run_long(3'b001, 32'hDEADBEEF, 32'h00010001, TO + 1, 1'b1, 7);
    run_short(3'b110, 32'h5A5A5A5A);

    // Reset in WAIT, then a late div_done that must be ignored.
    run_short(3'b100, 32'hA5A5A5A5);
    req_valid = 1'b1; req_op = 3'b011; req_a = 32'd50; req_b = 32'd3;
    quiet_units();
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    req_valid = 1'b0;
    hi_m = '0;
    lo_m = '0;
    for (int c = 0; c < 5; c++) begin
      quiet_units();
      if (c == 2) begin div_done = 1'b1; div_q = 32'd16; div_r = 32'd2; end
      @(negedge clk);
      chk("rstw_stall", stall, 0);
      chk("rstw_hi", hi, 0);
      chk("rstw_lo", lo, 0);
      next_cycle();
    end

    for (int n = 0; n < 60; n++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      int k, sel;
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (sel < 2) begin
        op = 3'($urandom_range(4, 7));
        run_short(op, a);
      end else begin
        op = 3'($urandom_range(0, 3));
        k  = $urandom_range(0, 19);
        if (k == 0 && $urandom_range(0, 3) != 0) k = 2;
        if (k == 1) k = TO + 1;
        run_long(op, a, b, k, 1'($urandom_range(0, 1)), $urandom_range(2, 8));
        if ($urandom_range(0, 2) == 0) check_idle_cycle("gap");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
